// File: rtl/audio_mixer_mc_pkg.sv
// Shared types and helpers for the time-multiplexed stereo mixer (package audio_mix_pkg).
package audio_mix_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } mix_state_e;

    localparam int DEF_GAIN_FRAC = 6;
    localparam int UNITY_GAIN    = 1 << DEF_GAIN_FRAC;

    // Wide enough that summing num_ch full-scale products can never wrap.
    function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
        return in_w + gain_w + $clog2(num_ch) + 1;
    endfunction

    // Clamp a sign-extended value into the signed range of w bits (w <= 63).
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
        if (v > mx)      return mx;
        else if (v < mn) return mn;
        else             return v;
    endfunction

endpackage

// File: rtl/audio_mixer_mc_if.sv
// Source-side / mixer-side bundle for audio_mixer_mc. Peak ports exist only with AUDIO_MIXER_MC_PEAK_EN.
interface audio_mixer_mc_if #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int GAIN_W = 8
);
    logic                        ce_2x;
    logic [NUM_CH*IN_W-1:0]      ch_l_in;
    logic [NUM_CH*IN_W-1:0]      ch_r_in;
    logic [NUM_CH*GAIN_W-1:0]    ch_gain;
    logic [NUM_CH-1:0]           ch_mute;
    logic signed [OUT_W-1:0]     mix_l_out;
    logic signed [OUT_W-1:0]     mix_r_out;
    logic                        mix_valid;
    logic                        busy;
    logic                        overrun;
`ifdef AUDIO_MIXER_MC_PEAK_EN
    logic                        peak_clr;
    logic [OUT_W-2:0]            peak_l;
    logic [OUT_W-2:0]            peak_r;

    modport master (output ce_2x, ch_l_in, ch_r_in, ch_gain, ch_mute, peak_clr,
                    input  mix_l_out, mix_r_out, mix_valid, busy, overrun, peak_l, peak_r);
    modport slave  (input  ce_2x, ch_l_in, ch_r_in, ch_gain, ch_mute, peak_clr,
                    output mix_l_out, mix_r_out, mix_valid, busy, overrun, peak_l, peak_r);
`else
    modport master (output ce_2x, ch_l_in, ch_r_in, ch_gain, ch_mute,
                    input  mix_l_out, mix_r_out, mix_valid, busy, overrun);
    modport slave  (input  ce_2x, ch_l_in, ch_r_in, ch_gain, ch_mute,
                    output mix_l_out, mix_r_out, mix_valid, busy, overrun);
`endif
endinterface

// File: rtl/audio_mixer_mc_mac.sv
// Single-lane signed sample x unsigned gain multiply-accumulate with clear and mute gate.
module audio_mix_mac #(
    parameter int IN_W   = 16,
    parameter int GAIN_W = 8,
    parameter int ACC_W  = 27
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    mute,
    input  logic signed [IN_W-1:0]  sample,
    input  logic [GAIN_W-1:0]       gain,
    output logic signed [ACC_W-1:0] acc
);
    localparam int PROD_W = IN_W + GAIN_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d, acc_q;

    always_comb begin
        // Gain is zero-extended so it stays positive inside the signed multiply.
        prod  = $signed(PROD_W'(sample)) * $signed(PROD_W'({1'b0, gain}));
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en && !mute)
            acc_d = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/audio_mixer_mc.sv
// Stereo mixer: one MAC per side walks the snapshotted channels, then shifts and saturates.
// Optional input/output peak meter enabled by AUDIO_MIXER_MC_PEAK_EN.
module audio_mixer_mc
    import audio_mix_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
    input logic              clk,
    input logic              reset,
    audio_mixer_mc_if.slave  bus
);
    localparam int ACC_W = acc_width(IN_W, GAIN_W, NUM_CH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    mix_state_e                    state_d, state_q;
    logic [IDX_W-1:0]              idx_d, idx_q;
    logic [NUM_CH-1:0][IN_W-1:0]   l_d, l_q, r_d, r_q;
    logic [NUM_CH-1:0][GAIN_W-1:0] gain_d, gain_q;
    logic [NUM_CH-1:0]             mute_d, mute_q;
    logic signed [OUT_W-1:0]       mix_l_d, mix_l_q, mix_r_d, mix_r_q;
    logic                          mix_valid_d, mix_valid_q;
    logic                          busy_d, busy_q;
    logic                          overrun_d, overrun_q;
    logic                          mac_clr, mac_en;
    logic signed [ACC_W-1:0]       acc_l, acc_r, sh_l, sh_r;

    audio_mix_mac #(.IN_W(IN_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_l (
        .clk(clk), .reset(reset), .clr(mac_clr), .en(mac_en), .mute(mute_q[idx_q]),
        .sample($signed(l_q[idx_q])), .gain(gain_q[idx_q]), .acc(acc_l)
    );

    audio_mix_mac #(.IN_W(IN_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_r (
        .clk(clk), .reset(reset), .clr(mac_clr), .en(mac_en), .mute(mute_q[idx_q]),
        .sample($signed(r_q[idx_q])), .gain(gain_q[idx_q]), .acc(acc_r)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        l_d         = l_q;
        r_d         = r_q;
        gain_d      = gain_q;
        mute_d      = mute_q;
        mix_l_d     = mix_l_q;
        mix_r_d     = mix_r_q;
        mix_valid_d = 1'b0;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        sh_l        = acc_l >>> GAIN_FRAC;
        sh_r        = acc_r >>> GAIN_FRAC;

        // A strobe during any non-idle cycle, OUTPUT included, is dropped and flagged.
        if (bus.ce_2x && state_q != IDLE)
            overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.ce_2x) begin
                    l_d     = bus.ch_l_in;
                    r_d     = bus.ch_r_in;
                    gain_d  = bus.ch_gain;
                    mute_d  = bus.ch_mute;
                    idx_d   = '0;
                    mac_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                mac_en = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_CH - 1)) begin
                    idx_d   = '0;
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                mix_l_d     = OUT_W'(sat_to_width(64'(sh_l), OUT_W));
                mix_r_d     = OUT_W'(sat_to_width(64'(sh_r), OUT_W));
                mix_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            gain_q      <= '0;
            mute_q      <= '0;
            mix_l_q     <= '0;
            mix_r_q     <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            l_q         <= l_d;
            r_q         <= r_d;
            gain_q      <= gain_d;
            mute_q      <= mute_d;
            mix_l_q     <= mix_l_d;
            mix_r_q     <= mix_r_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.mix_l_out = mix_l_q;
    assign bus.mix_r_out = mix_r_q;
    assign bus.mix_valid = mix_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

`ifdef AUDIO_MIXER_MC_PEAK_EN
    logic [OUT_W-2:0] peak_l_d, peak_l_q, peak_r_d, peak_r_q, abs_l, abs_r;

    // Magnitude in OUT_W-1 bits; the most negative code clamps to full scale.
    function automatic logic [OUT_W-2:0] mag(input logic signed [OUT_W-1:0] v);
        if (!v[OUT_W-1])                        return v[OUT_W-2:0];
        else if (v[OUT_W-2:0] == '0)            return '1;
        else                                    return (OUT_W-1)'(-v);
    endfunction

    always_comb begin
        abs_l    = mag(mix_l_q);
        abs_r    = mag(mix_r_q);
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        if (mix_valid_q) begin
            peak_l_d = (bus.peak_clr || abs_l > peak_l_q) ? abs_l : peak_l_q;
            peak_r_d = (bus.peak_clr || abs_r > peak_r_q) ? abs_r : peak_r_q;
        end else if (bus.peak_clr) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign bus.peak_l = peak_l_q;
    assign bus.peak_r = peak_r_q;
`endif
endmodule

// File: tb/tb_audio_mixer_mc.sv
// Randomised and directed bench for audio_mixer_mc against an arithmetic mix model.
module tb_audio_mixer_mc;
    localparam int NUM_CH    = 4;
    localparam int IN_W      = 16;
    localparam int OUT_W     = 16;
    localparam int GAIN_W    = 8;
    localparam int GAIN_FRAC = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_mixer_mc_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) bus ();

    audio_mixer_mc #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W),
                     .GAIN_FRAC(GAIN_FRAC)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    int cur_l [NUM_CH];
    int cur_r [NUM_CH];
    int cur_g [NUM_CH];
    bit cur_m [NUM_CH];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected mix for one side: sum of gated products, floor-shifted, clamped.
    function automatic longint model(input bit right);
        longint s = 0;
        longint mx = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint mn = -(longint'(1) <<< (OUT_W - 1));
        for (int k = 0; k < NUM_CH; k++)
            if (!cur_m[k]) s += longint'(right ? cur_r[k] : cur_l[k]) * longint'(cur_g[k]);
        s = s >>> GAIN_FRAC;
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        return s;
    endfunction

    task automatic drive_cur();
        for (int k = 0; k < NUM_CH; k++) begin
            bus.ch_l_in[k*IN_W +: IN_W]     = IN_W'(cur_l[k]);
            bus.ch_r_in[k*IN_W +: IN_W]     = IN_W'(cur_r[k]);
            bus.ch_gain[k*GAIN_W +: GAIN_W] = GAIN_W'(cur_g[k]);
            bus.ch_mute[k]                  = cur_m[k];
        end
    endtask

    task automatic scramble();
        bus.ch_l_in = {$urandom, $urandom};
        bus.ch_r_in = {$urandom, $urandom};
        bus.ch_gain = $urandom;
        bus.ch_mute = NUM_CH'($urandom);
    endtask

    task automatic set_all(input int l, input int r, input int g);
        for (int k = 0; k < NUM_CH; k++) begin
            cur_l[k] = l; cur_r[k] = r; cur_g[k] = g; cur_m[k] = 1'b0;
        end
    endtask

    task automatic randomize_cur();
        logic signed [IN_W-1:0] t;
        for (int k = 0; k < NUM_CH; k++) begin
            t = IN_W'($urandom); cur_l[k] = int'(t);
            t = IN_W'($urandom); cur_r[k] = int'(t);
            cur_g[k] = $urandom_range(0, 255);
            cur_m[k] = ($urandom_range(0, 3) == 0);
        end
    endtask

    // One full pass: strobe, scramble inputs mid-pass, check latency, values and pulse width.
    task automatic run_pass(input string tag);
        int lat;
        longint el, er;
        el = model(1'b0);
        er = model(1'b1);
        @(negedge clk);
        drive_cur();
        bus.ce_2x = 1'b1;
        @(negedge clk);
        bus.ce_2x = 1'b0;
        scramble();
        chk({tag, "_busy"}, longint'(bus.busy), 1);
        lat = 0;
        while (!bus.mix_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_l"}, longint'(bus.mix_l_out), el);
        chk({tag, "_r"}, longint'(bus.mix_r_out), er);
        chk({tag, "_busy_at_valid"}, longint'(bus.busy), 0);
        @(negedge clk);
        chk({tag, "_pulse"}, longint'(bus.mix_valid), 0);
        chk({tag, "_hold"}, longint'(bus.mix_l_out), el);
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.mix_valid) n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b1;
        bus.ce_2x = 1'b0;
        bus.ch_l_in = '0;
        bus.ch_r_in = '0;
        bus.ch_gain = '0;
        bus.ch_mute = '0;
        do_reset();

        chk("rst_l", longint'(bus.mix_l_out), 0);
        chk("rst_r", longint'(bus.mix_r_out), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_ovr", longint'(bus.overrun), 0);
        scramble();
        count_valid(12, n);
        chk("idle_no_valid", n, 0);

        // Unity gain
        set_all(100, 100, 64);
        cur_l[0] = 1000; cur_l[1] = 2000; cur_l[2] = -500; cur_l[3] = 0;
        run_pass("unity");
        chk("unity_l_const", longint'(bus.mix_l_out), 2500);
        chk("unity_r_const", longint'(bus.mix_r_out), 400);

        // Saturation
        set_all(32767, 0, 64);
        run_pass("sat_pos");
        chk("sat_pos_const", longint'(bus.mix_l_out), 32767);
        set_all(-32768, 0, 64);
        run_pass("sat_neg");
        chk("sat_neg_const", longint'(bus.mix_l_out), -32768);
        set_all(0, 0, 0);
        cur_l[2] = 20000; cur_g[2] = 128;
        run_pass("sat_gain");
        chk("sat_gain_const", longint'(bus.mix_l_out), 32767);

        // Gain and mute
        set_all(0, 300, 64);
        cur_l[0] = 8000; cur_g[0] = 32;
        cur_l[1] = 600;
        run_pass("gain");
        chk("gain_const", longint'(bus.mix_l_out), 4600);
        cur_m[0] = 1'b1;
        run_pass("mute");
        chk("mute_const", longint'(bus.mix_l_out), 600);
        chk("mute_r_const", longint'(bus.mix_r_out), 900);

        // Random passes
        for (int i = 0; i < 25; i++) begin
            randomize_cur();
            run_pass("rand");
        end
        chk("no_ovr_yet", longint'(bus.overrun), 0);

        // Overrun: second strobe two cycles into a pass
        set_all(1000, -1000, 64);
        @(negedge clk);
        drive_cur();
        bus.ce_2x = 1'b1;
        @(negedge clk);
        bus.ce_2x = 1'b0;
        scramble();
        @(negedge clk);
        bus.ce_2x = 1'b1;
        @(negedge clk);
        bus.ce_2x = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.mix_valid) begin
                n++;
                chk("ovr_l", longint'(bus.mix_l_out), 4000);
                chk("ovr_r", longint'(bus.mix_r_out), -4000);
            end
            @(negedge clk);
        end
        chk("ovr_one_valid", n, 1);
        chk("ovr_set", longint'(bus.overrun), 1);
        randomize_cur();
        run_pass("after_ovr");
        chk("ovr_sticky", longint'(bus.overrun), 1);

        // Reset mid-pass
        set_all(5000, 2000, 64);
        run_pass("pre_rst");
        @(negedge clk);
        bus.ce_2x = 1'b1;
        @(negedge clk);
        bus.ce_2x = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_valid(12, n);
        chk("rst_mid_no_valid", n, 0);
        chk("rst_mid_l", longint'(bus.mix_l_out), 0);
        chk("rst_mid_r", longint'(bus.mix_r_out), 0);
        chk("rst_mid_ovr", longint'(bus.overrun), 0);
        chk("rst_mid_busy", longint'(bus.busy), 0);
        randomize_cur();
        run_pass("post_rst");

        // Strobe coincident with reset
        @(negedge clk);
        reset = 1'b1;
        bus.ce_2x = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.ce_2x = 1'b0;
        chk("rst_ce_busy", longint'(bus.busy), 0);
        count_valid(10, n);
        chk("rst_ce_no_valid", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/audio_mixer_mc.md
Name: audio_mixer_mc

Overview:
- Parametrised stereo mixer that sums NUM_CH signed PCM stereo sources into one stereo output.
- Each channel has an individual gain and a mute control.
- Output is saturated rather than wrapped.
- A time-multiplexed multiply-accumulate runs once per sample strobe (ce_2x).
- Sits between the synth cores (FM, PSG, PCM) and the audio output path.

Parameters:
- NUM_CH, 4: number of stereo input channels (2..16).
- IN_W, 16: input sample width, signed two's complement.
- OUT_W, 16: output sample width, signed; OUT_W <= IN_W+2.
- GAIN_W, 8: per-channel unsigned gain width.
- GAIN_FRAC, 6: fractional bits of gain; the value 1<<GAIN_FRAC is unity gain.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_2x  in  1  sample strobe; starts one mix pass
- ch_l_in  in  NUM_CH*IN_W  left samples; channel k at bits [k*IN_W +: IN_W]
- ch_r_in  in  NUM_CH*IN_W  right samples, same packing
- ch_gain  in  NUM_CH*GAIN_W  per-channel gain, same packing scheme
- ch_mute  in  NUM_CH  bit k=1 forces channel k contribution to 0
- mix_l_out  out  OUT_W  saturated left mix
- mix_r_out  out  OUT_W  saturated right mix
- mix_valid  out  1  one-cycle pulse when mix_*_out update
- busy  out  1  high while a pass is in progress
- overrun  out  1  sticky; set when ce_2x arrives while busy

Behaviour:
- One clock (clk). Reset is synchronous and active-high on port reset. Reset forces FSM=IDLE, both accumulators=0, mix_l_out=0, mix_r_out=0, mix_valid=0, busy=0, overrun=0, channel index=0.
- FSM states:
  - IDLE:
    - On ce_2x, snapshot ch_l_in, ch_r_in, ch_gain and ch_mute into registers.
    - Clear both accumulators and set idx=0.
    - Go to ACCUM; busy=1 from the next cycle.
  - ACCUM:
    - Each cycle, acc_l += mute[idx] ? 0 : l[idx]*gain[idx], and likewise for acc_r.
    - The product is a signed sample times a zero-extended unsigned gain.
    - idx increments each cycle. After idx=NUM_CH-1 is processed, go to OUTPUT.
  - OUTPUT:
    - Compute acc >>> GAIN_FRAC (arithmetic shift).
    - Saturate to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
    - Register the result to mix_*_out and pulse mix_valid for 1 cycle.
    - Go to IDLE; busy=0 in the same cycle mix_valid is high.
- Accumulator width: IN_W+GAIN_W+clog2(NUM_CH)+1, so accumulation never wraps. Saturation happens only at output.
- Latency: mix_valid is asserted NUM_CH+1 cycles after the ce_2x cycle. mix_*_out hold their value between passes.
- Inputs are sampled only at pass start; input changes during a pass do not affect that pass.
- ce_2x while busy (including the OUTPUT cycle): the strobe is ignored, the current pass continues, and overrun is set. overrun is cleared only by reset.
- ce_2x in the same cycle as reset: reset wins; no pass starts.
- Reset mid-pass: the pass is aborted, outputs return to 0, and mix_valid is not pulsed.
- Gain 0 or mute gives a zero contribution. Gain above unity amplifies; saturation clamps the result.

Optional Feature:
- Macro: AUDIO_MIXER_MC_PEAK_EN.
- Defined:
  - Adds input peak_clr (1) and outputs peak_l, peak_r (OUT_W-1 bits, unsigned).
  - On each mix_valid, peak_x = max(peak_x, |mix_x_out|), where |-(2^(OUT_W-1))| is clamped to 2^(OUT_W-1)-1.
  - peak_clr zeroes both peaks. If peak_clr coincides with mix_valid, the peak loads the new |value|.
  - Reset zeroes both peaks.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package audio_mix_pkg holds:
  - FSM state enum (IDLE, ACCUM, OUTPUT)
  - ACC_W calculation function
  - sat_to_width function
  - unity gain constant
- One natural sub-module, audio_mix_mac: a single-lane signed multiply-accumulate with clear and mute-gate. It is instantiated twice, once for L and once for R.

Test Plan:
- Reset then idle: all outputs are 0 and mix_valid never pulses without ce_2x.
- Unity pass, NUM_CH=4, gains=64, L={1000,2000,-500,0}, R=all 100; pulse ce_2x -> mix_valid exactly 5 cycles later, mix_l_out=2500, mix_r_out=400.
- Saturation: all L=32767, gains=64 -> mix_l_out=32767. All L=-32768 -> mix_l_out=-32768. Gain=128 on a single channel with 20000 -> 32767.
- Mute and gain: channel 0 L=8000 with gain 32 gives 4000. Then mute channel 0 -> next pass mix_l_out=0, other channels unaffected.
- Overrun: ce_2x, then ce_2x again 2 cycles later -> one mix_valid only, overrun=1 and stays 1 until reset.
- Reset mid-pass: reset 2 cycles after ce_2x -> no mix_valid, outputs 0. Next ce_2x produces a correct result.
